// File: rtl/raycast_pkg.sv
// Shared raycaster types and constants.
// Palette, descriptor layout and screen defaults.
package raycast_pkg;

  localparam int DEF_SCREEN_WIDTH  = 320;
  localparam int DEF_SCREEN_HEIGHT = 240;

  localparam int DESC_W      = 38;
  localparam int HCOUNT_LSB  = 29;
  localparam int LH_LSB      = 21;
  localparam int WTYPE_BIT   = 20;
  localparam int MAPDATA_LSB = 16;
  localparam int WALLX_LSB   = 0;

  typedef struct packed {
    logic [8:0]  hcount;
    logic [7:0]  lineheight;
    logic        wall_type;
    logic [3:0]  mapdata;
    logic [15:0] wallx;
  } column_desc_t;

  localparam logic [15:0] PALETTE [0:15] = '{
    16'h0000, 16'hF800, 16'h07E0, 16'h001F,
    16'hFFE0, 16'hF81F, 16'h07FF, 16'hFFFF,
    16'h8000, 16'h0400, 16'h0010, 16'h8400,
    16'h8010, 16'h0410, 16'hC618, 16'hFD20
  };

  function automatic logic [15:0] shade(
    input logic [15:0] c
  );
    return (c >> 1) & 16'h7BEF;
  endfunction

endpackage

// File: rtl/column_bounds.sv
// Wall span of one column.
// Pure combinational; the parent registers the results.
module column_bounds #(
  parameter int SCREEN_HEIGHT = 240,
  parameter int ROW_W         = 8
) (
  input  logic [7:0]       lineheight,
  output logic [ROW_W-1:0] draw_start,
  output logic [ROW_W-1:0] draw_end,
  output logic             has_wall
);

  localparam logic [15:0] H16 = 16'(SCREEN_HEIGHT);

  logic [15:0] lh16;
  logic [15:0] lh_c;
  logic [15:0] start16;
  logic [15:0] end16;

  // clamp height, centre the span vertically
  always_comb begin
    lh16    = {8'd0, lineheight};
    lh_c    = (lh16 > H16) ? H16 : lh16;
    start16 = (H16 - lh_c) >> 1;
    end16   = start16 + lh_c - 16'd1;
  end

  assign draw_start = ROW_W'(start16);
  assign draw_end   = ROW_W'(end16);
  assign has_wall   = (lh_c != 16'd0);

endmodule

// File: rtl/column_rasterizer.sv
// Expands one column descriptor into SCREEN_HEIGHT
// frame-buffer writes (ceiling, wall, floor).
module column_rasterizer
  import raycast_pkg::*;
#(
  parameter int          SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
  parameter int          SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
  parameter logic [15:0] CEIL_COLOR    = 16'h4208,
  parameter logic [15:0] FLOOR_COLOR   = 16'h8410
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic        dda_fifo_tvalid_in,
  input  logic [37:0] dda_fifo_tdata_in,
  input  logic        dda_fifo_tlast_in,
  output logic        dda_fifo_tready_out,
  output logic [16:0] ray_address_out,
  output logic [15:0] ray_pixel_out,
  output logic        ray_valid_out,
  input  logic        ray_ready_in,
  output logic        ray_last_pixel_out
);

  localparam int ROW_W = $clog2(SCREEN_HEIGHT + 1);
  localparam logic [ROW_W-1:0] LAST_ROW =
    ROW_W'(SCREEN_HEIGHT - 1);
  localparam logic [16:0] W17 = 17'(SCREEN_WIDTH);

  localparam logic IDLE = 1'b0;
  localparam logic DRAW = 1'b1;

  column_desc_t desc;
  assign desc = dda_fifo_tdata_in;

  logic unused_wallx;
  assign unused_wallx = ^desc.wallx;

  logic [ROW_W-1:0] bnd_start;
  logic [ROW_W-1:0] bnd_end;
  logic             bnd_has;

  column_bounds #(
    .SCREEN_HEIGHT(SCREEN_HEIGHT),
    .ROW_W        (ROW_W)
  ) u_bounds (
    .lineheight(desc.lineheight),
    .draw_start(bnd_start),
    .draw_end  (bnd_end),
    .has_wall  (bnd_has)
  );

  logic             state_q;
  logic [ROW_W-1:0] row_q;
  logic [16:0]      addr_q;
  logic [ROW_W-1:0] start_q;
  logic [ROW_W-1:0] end_q;
  logic             has_q;
  logic [15:0]      wall_q;
  logic             tlast_q;
  logic             valid_q;
  logic             last_q;
  logic [15:0]      pixel_q;
  logic             ready_q;

  logic             accept;
  logic             in_range;
  logic [15:0]      wall_in;
  logic [ROW_W-1:0] row_nxt;

  function automatic logic [15:0] pick(
    input logic [ROW_W-1:0] r,
    input logic [ROW_W-1:0] s,
    input logic [ROW_W-1:0] e,
    input logic             has,
    input logic [15:0]      wc
  );
    if (r < s)
      return CEIL_COLOR;
    else if (has && r <= e)
      return wc;
    else
      return FLOOR_COLOR;
  endfunction

  // handshake decode and colour of the incoming wall
  always_comb begin
    accept   = (state_q == IDLE) && ready_q &&
               dda_fifo_tvalid_in;
    in_range = {8'd0, desc.hcount} < W17;
    wall_in  = desc.wall_type ?
               shade(PALETTE[desc.mapdata]) :
               PALETTE[desc.mapdata];
    row_nxt  = row_q + ROW_W'(1);
  end

  // column FSM with registered outputs
  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      row_q   <= '0;
      addr_q  <= '0;
      start_q <= '0;
      end_q   <= '0;
      has_q   <= 1'b0;
      wall_q  <= '0;
      tlast_q <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      pixel_q <= '0;
      ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (accept && in_range) begin
            state_q <= DRAW;
            ready_q <= 1'b0;
            row_q   <= '0;
            addr_q  <= {8'd0, desc.hcount};
            start_q <= bnd_start;
            end_q   <= bnd_end;
            has_q   <= bnd_has;
            wall_q  <= wall_in;
            tlast_q <= dda_fifo_tlast_in;
            valid_q <= 1'b1;
            pixel_q <= pick('0, bnd_start, bnd_end,
                            bnd_has, wall_in);
            last_q  <= dda_fifo_tlast_in &&
                       (LAST_ROW == '0);
          end
        end
        DRAW: begin
          if (ray_ready_in) begin
            if (row_q == LAST_ROW) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              ready_q <= 1'b1;
            end else begin
              row_q   <= row_nxt;
              addr_q  <= addr_q + W17;
              pixel_q <= pick(row_nxt, start_q, end_q,
                              has_q, wall_q);
              last_q  <= tlast_q && (row_nxt == LAST_ROW);
            end
          end
        end
      endcase
    end
  end

  assign dda_fifo_tready_out = ready_q;
  assign ray_address_out     = addr_q;
  assign ray_pixel_out       = pixel_q;
  assign ray_valid_out       = valid_q;
  assign ray_last_pixel_out  = last_q;

endmodule

// File: tb/tb_column_rasterizer.sv
// Directed and stalled-stream checks for
// column_rasterizer at 320x240.
module tb_column_rasterizer;

  logic        clk;
  logic        rst_n;
  logic        tvalid;
  logic [37:0] tdata;
  logic        tlast;
  logic        tready;
  logic [16:0] addr;
  logic [15:0] pix;
  logic        valid;
  logic        ready_in;
  logic        last;

  int n_checks = 0;
  int n_fail   = 0;
  int n_xfer   = 0;
  int n_dup    = 0;
  bit seen [0:76799];

  localparam logic [15:0] CEIL  = 16'h4208;
  localparam logic [15:0] FLOOR = 16'h8410;

  logic [15:0] tb_pal [0:15];

  column_rasterizer dut (
    .pixel_clk_in       (clk),
    .rst_in             (rst_n),
    .dda_fifo_tvalid_in (tvalid),
    .dda_fifo_tdata_in  (tdata),
    .dda_fifo_tlast_in  (tlast),
    .dda_fifo_tready_out(tready),
    .ray_address_out    (addr),
    .ray_pixel_out      (pix),
    .ray_valid_out      (valid),
    .ray_ready_in       (ready_in),
    .ray_last_pixel_out (last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          hc;
    int          lh;
    bit          wt;
    int          md;
    bit          tl;
    int          stall;
    int          lo;
    int          hi;
    logic [15:0] wpix;
  } vec_t;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_pix(
    input int r, input int lo, input int hi,
    input logic [15:0] w);
    if (r < lo) return CEIL;
    if (r <= hi) return w;
    return FLOOR;
  endfunction

  task automatic send(input int hc, input int lh,
                      input bit wt, input int md,
                      input bit tl);
    int b;
    b = 0;
    while (!tready && b < 20) begin
      @(negedge clk);
      b++;
    end
    if (b == 20) chk("tready_wait", 32'(tready), 1);
    tvalid = 1'b1;
    tdata  = {9'(hc), 8'(lh), wt, 4'(md), 16'hABCD};
    tlast  = tl;
    @(negedge clk);
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic collect(input int hc, input int lo,
                         input int hi,
                         input logic [15:0] w,
                         input bit tl, input int stall,
                         input bit verbose);
    int r, errs, budget, ea;
    bit held, el;
    logic [16:0] ha;
    logic [15:0] hp, ep;
    logic hl;
    r = 0; errs = 0; budget = 0; held = 0;
    ha = '0; hp = '0; hl = 1'b0;
    while (r < 240 && budget < 1500) begin
      if (held) begin
        if (verbose) begin
          chk("stall_addr", 32'(addr), 32'(ha));
          chk("stall_pix", 32'(pix), 32'(hp));
          chk("stall_last", 32'(last), 32'(hl));
        end else if (addr !== ha || pix !== hp ||
                     last !== hl) begin
          errs++;
        end
      end
      ready_in = ($urandom_range(99) >= stall);
      if (!valid) begin
        if (verbose) chk("valid_drop", 32'(valid), 1);
        else errs++;
      end
      if (valid && ready_in) begin
        ea = r * 320 + hc;
        ep = exp_pix(r, lo, hi, w);
        el = tl && (r == 239);
        if (verbose) begin
          chk($sformatf("addr h%0d r%0d", hc, r),
              32'(addr), 32'(ea));
          chk($sformatf("pix h%0d r%0d", hc, r),
              32'(pix), 32'(ep));
          chk($sformatf("last h%0d r%0d", hc, r),
              32'(last), 32'(el));
        end else begin
          if (addr !== 17'(ea) || pix !== ep ||
              last !== el) begin
            if (errs == 0)
              $display("first diff h%0d r%0d: %h/%h %h/%h",
                       hc, r, addr, 17'(ea), pix, ep);
            errs++;
          end
          if (addr < 17'd76800) begin
            if (seen[addr]) n_dup++;
            seen[addr] = 1'b1;
          end
          n_xfer++;
        end
        r++;
        held = 0;
      end else begin
        held = valid;
        ha = addr; hp = pix; hl = last;
      end
      @(negedge clk);
      budget++;
    end
    if (r < 240) chk("column_timeout", 32'(r), 240);
    ready_in = 1'b1;
    if (verbose) begin
      chk("idle_valid", 32'(valid), 0);
      chk("idle_tready", 32'(tready), 1);
    end else begin
      if (valid !== 1'b0 || tready !== 1'b1) errs++;
      chk($sformatf("col%0d errors", hc), 32'(errs), 0);
    end
  endtask

  vec_t vecs [7];

  initial begin
    int lh, lhc, lo, hi, md, errs;
    bit wt;
    logic [15:0] w;

    tb_pal = '{
      16'h0000, 16'hF800, 16'h07E0, 16'h001F,
      16'hFFE0, 16'hF81F, 16'h07FF, 16'hFFFF,
      16'h8000, 16'h0400, 16'h0010, 16'h8400,
      16'h8010, 16'h0410, 16'hC618, 16'hFD20
    };

    vecs[0] = '{5,   100, 0, 3, 0, 0,  70, 169, 16'h001F};
    vecs[1] = '{7,   101, 1, 3, 0, 30, 69, 169, 16'h000F};
    vecs[2] = '{9,   255, 0, 1, 0, 0,  0,  239, 16'hF800};
    vecs[3] = '{10,  0,   0, 2, 0, 0,  120, 119, 16'h07E0};
    vecs[4] = '{0,   1,   0, 4, 0, 20, 119, 119, 16'hFFE0};
    vecs[5] = '{2,   200, 1, 0, 0, 0,  20, 219, 16'h0000};
    vecs[6] = '{319, 240, 1, 1, 1, 0,  0,  239, 16'h7800};

    rst_n    = 1'b0;
    tvalid   = 1'b0;
    tdata    = '0;
    tlast    = 1'b0;
    ready_in = 1'b1;
    #12;
    chk("rst_valid", 32'(valid), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_pix", 32'(pix), 0);
    chk("rst_last", 32'(last), 0);
    chk("rst_tready", 32'(tready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("tready_pre_edge", 32'(tready), 0);
    @(negedge clk);
    chk("tready_after_edge", 32'(tready), 1);

    foreach (vecs[i]) begin
      send(vecs[i].hc, vecs[i].lh, vecs[i].wt,
           vecs[i].md, vecs[i].tl);
      chk("latency_valid", 32'(valid), 1);
      chk("draw_tready", 32'(tready), 0);
      collect(vecs[i].hc, vecs[i].lo, vecs[i].hi,
              vecs[i].wpix, vecs[i].tl, vecs[i].stall, 1);
    end

    send(320, 100, 0, 3, 1);
    errs = 0;
    for (int k = 0; k < 4; k++) begin
      if (valid !== 1'b0 || tready !== 1'b1) errs++;
      @(negedge clk);
    end
    chk("drop_hc320", 32'(errs), 0);

    send(20, 100, 0, 3, 0);
    ready_in = 1'b1;
    repeat (50) @(negedge clk);
    chk("row50_addr", 32'(addr), 32'(50 * 320 + 20));
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(valid), 0);
    chk("midrst_addr", 32'(addr), 0);
    chk("midrst_pix", 32'(pix), 0);
    chk("midrst_tready", 32'(tready), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(21, 100, 0, 3, 0);
    chk("restart_addr", 32'(addr), 21);
    collect(21, 70, 169, 16'h001F, 0, 0, 1);

    foreach (seen[a]) seen[a] = 1'b0;
    n_xfer = 0;
    n_dup  = 0;
    for (int c = 0; c < 320; c++) begin
      lh  = $urandom_range(255);
      wt  = 1'($urandom_range(1));
      md  = $urandom_range(15);
      lhc = (lh > 240) ? 240 : lh;
      lo  = (240 - lhc) / 2;
      hi  = lo + lhc - 1;
      w   = wt ? ((tb_pal[md] >> 1) & 16'h7BEF)
               : tb_pal[md];
      send(c, lh, wt, md, c == 319);
      collect(c, lo, hi, w, c == 319, 4, 0);
    end
    chk("frame_xfers", 32'(n_xfer), 76800);
    chk("frame_dups", 32'(n_dup), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/column_rasterizer.md
COLUMN_RASTERIZER -- requirements
Module: column_rasterizer

Interface
REQ-001 Parameter SCREEN_WIDTH, default 320: columns per frame; valid hcount range 0..SCREEN_WIDTH-1.
REQ-002 Parameter SCREEN_HEIGHT, default 240: rows per column.
REQ-003 Parameter CEIL_COLOR, default 16'h4208: RGB565 value for rows above the wall.
REQ-004 Parameter FLOOR_COLOR, default 16'h8410: RGB565 value for rows below the wall.
REQ-005 Port pixel_clk_in, input, 1: the single clock; reset is asynchronous and active-low.
REQ-006 Port rst_in, input, 1: asynchronous, active-low reset.
REQ-007 Port dda_fifo_tvalid_in, input, 1: column descriptor valid.
REQ-008 Port dda_fifo_tdata_in, input, 38: descriptor fields are {hcount[37:29], lineheight[28:21], wall_type[20], mapdata[19:16], wallX[15:0]}.
REQ-009 Port dda_fifo_tlast_in, input, 1: the descriptor is the last column of the frame.
REQ-010 Port dda_fifo_tready_out, output, 1: the block accepts a descriptor.
REQ-011 Port ray_address_out, output, 17: frame-buffer address, computed as row*SCREEN_WIDTH+hcount.
REQ-012 Port ray_pixel_out, output, 16: RGB565 pixel value.
REQ-013 Port ray_valid_out, output, 1: address and pixel are valid.
REQ-014 Port ray_ready_in, input, 1: the frame buffer accepts the write.
REQ-015 Port ray_last_pixel_out, output, 1: marks the final pixel of the frame.

Function
REQ-016 The FSM SHALL have two states: IDLE and DRAW. dda_fifo_tready_out SHALL be 1 only in IDLE.
REQ-017 IDLE: on tvalid&&tready, the block SHALL latch hcount, wall_type, mapdata and tlast, compute the bounds, set row=0 and addr=hcount, and enter DRAW. wallX is ignored in this revision.
REQ-018 Bounds: lh_c = min(lineheight, SCREEN_HEIGHT); draw_start = (SCREEN_HEIGHT-lh_c)>>1 (floor); draw_end = draw_start+lh_c-1. When lh_c==0, no row is wall.
REQ-019 DRAW: ray_valid_out SHALL be 1. A transfer occurs when ray_valid_out&&ray_ready_in.
REQ-020 On each transfer, row SHALL increment by 1 and addr SHALL increment by SCREEN_WIDTH. No multiplier is permitted.
REQ-021 When ray_ready_in is low, all outputs SHALL hold stable.
REQ-022 Pixel colour: row<draw_start gives CEIL_COLOR; draw_start<=row<=draw_end gives PALETTE[mapdata]; row>draw_end gives FLOOR_COLOR.
REQ-023 When wall_type==1, the wall colour SHALL be shaded as (PALETTE[mapdata]>>1)&16'h7BEF. Ceiling and floor colours are never shaded.
REQ-024 ray_last_pixel_out SHALL be 1 only on row SCREEN_HEIGHT-1 of a column whose latched tlast==1.
REQ-025 After the transfer of row SCREEN_HEIGHT-1, the FSM SHALL return to IDLE. Exactly SCREEN_HEIGHT transfers occur per column, and there is one idle cycle between columns.
REQ-026 Latency: the first pixel SHALL be valid on the cycle after the descriptor is accepted.
REQ-027 A descriptor with hcount>=SCREEN_WIDTH SHALL be accepted and dropped: no output, FSM stays in IDLE. If that descriptor carries tlast, the tlast is lost.
REQ-028 Outputs SHALL be registered; no combinational path from ray_ready_in to ray_valid_out.

Reset
REQ-029 When rst_in==0, asynchronously: state=IDLE, row=0, addr=0, and ray_valid_out, ray_last_pixel_out, ray_address_out, ray_pixel_out and dda_fifo_tready_out are all 0.
REQ-030 dda_fifo_tready_out SHALL rise on the first clock edge after rst_in deasserts.
REQ-031 Reset asserted mid-column SHALL abandon the column. After release, the next accepted descriptor starts at row 0.

Structure
REQ-032 Package raycast_pkg SHALL hold: the 16-entry RGB565 PALETTE (entry 0 = 16'h0000), the descriptor field offsets, the column_desc_t packed struct, and the SCREEN_WIDTH/SCREEN_HEIGHT defaults.
REQ-033 Sub-module column_bounds SHALL be combinational: lineheight in, draw_start/draw_end out. The parent latches its outputs.

Verification
REQ-034 Descriptor hcount=5, lh=100, wall_type=0, mapdata=3, ray_ready_in=1 -> 240 pixels. Addresses 5, 325, ... 76485. Rows 0-69 CEIL, rows 70-169 PALETTE[3], rows 170-239 FLOOR.
REQ-035 lh=101, wall_type=1 -> wall rows 69-169, each pixel equal to (PALETTE[mapdata]>>1)&16'h7BEF.
REQ-036 lh=255 and lh=0 -> rows 0-239 all wall; then rows 0-119 CEIL and rows 120-239 FLOOR.
REQ-037 hcount=319 with tlast=1 -> ray_last_pixel_out=1 only on address 76799. Descriptor hcount=320 -> accepted, zero output.
REQ-038 Random ray_ready_in stalls over 320 back-to-back columns -> outputs stable during stalls and 76800 transfers with no duplicate addresses. An rst_in pulse at row 50 -> outputs zero immediately and the next column restarts at row 0.
